// File: rtl/riscv_defines.sv
// Shared decode-stage types and constants for the immediate generator.
package riscv_defines;

  // Instruction format as resolved by the decoder; Z_TYPE covers CSR immediate forms.
  typedef enum logic [2:0] {
    R_TYPE = 3'd0,
    I_TYPE = 3'd1,
    S_TYPE = 3'd2,
    B_TYPE = 3'd3,
    U_TYPE = 3'd4,
    J_TYPE = 3'd5,
    Z_TYPE = 3'd6
  } inst_format_e;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Bundle handshake between fetch/decode (master) and the immediate generator (slave).
interface imm_gen_pipe_if #(
  parameter int unsigned LANES = 2,
  parameter int unsigned XLEN  = 32
) ();
  import riscv_defines::*;

  logic                            in_valid;
  logic                            in_ready;
  logic [LANES-1:0]                in_lane_valid;
  logic [LANES-1:0][31:0]          in_instr;
  inst_format_e [LANES-1:0]        in_format;
  logic [XLEN-1:0]                 in_pc;

  logic                            out_valid;
  logic                            out_ready;
  logic [LANES-1:0]                out_lane_valid;
  logic [LANES-1:0][XLEN-1:0]      out_imm;
  logic [LANES-1:0][XLEN-1:0]      out_target;

  modport master (
    output in_valid, in_lane_valid, in_instr, in_format, in_pc, out_ready,
    input  in_ready, out_valid, out_lane_valid, out_imm, out_target
  );

  modport slave (
    input  in_valid, in_lane_valid, in_instr, in_format, in_pc, out_ready,
    output in_ready, out_valid, out_lane_valid, out_imm, out_target
  );

endinterface

// File: rtl/imm_extract.sv
// Combinational immediate extraction and PC-relative target for a single lane.
module imm_extract
  import riscv_defines::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  inst_format_e    format_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] target_o
);

  logic [31:0] imm32;
  logic        unused_opcode;

  // Opcode bits never contribute to an immediate.
  assign unused_opcode = ^instr_i[6:0];

  // Build the 32-bit immediate; Z has bit 31 clear so the widening below zero-extends it.
  always_comb begin
    imm32 = '0;
    case (format_i)
      I_TYPE:  imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      S_TYPE:  imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      B_TYPE:  imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      U_TYPE:  imm32 = {instr_i[31:12], 12'b0};
      J_TYPE:  imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
      Z_TYPE:  imm32 = {27'b0, instr_i[19:15]};
      default: imm32 = '0;
    endcase
  end

  assign imm_o    = XLEN'($signed(imm32));
  assign target_o = pc_i + imm_o;

endmodule

// File: rtl/imm_gen_pipe.sv
// Multi-lane immediate generator with a main (M) and skid (S) output register pair.
module imm_gen_pipe
  import riscv_defines::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned XLEN  = 32
) (
  input logic           clk,
  input logic           rst_n,
  input logic           flush,
  imm_gen_pipe_if.slave bus
);

  logic [LANES-1:0][XLEN-1:0] in_imm, in_target;

  logic                       m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic [LANES-1:0]           m_lv_q, m_lv_d, s_lv_q, s_lv_d;
  logic [LANES-1:0][XLEN-1:0] m_imm_q, m_imm_d, s_imm_q, s_imm_d;
  logic [LANES-1:0][XLEN-1:0] m_tgt_q, m_tgt_d, s_tgt_q, s_tgt_d;
  logic                       accept;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [XLEN-1:0] lane_pc;
    assign lane_pc = bus.in_pc + XLEN'(l * INSTR_BYTES);

    imm_extract #(
      .XLEN(XLEN)
    ) u_imm_extract (
      .instr_i (bus.in_instr[l]),
      .format_i(bus.in_format[l]),
      .pc_i    (lane_pc),
      .imm_o   (in_imm[l]),
      .target_o(in_target[l])
    );
  end

  // Ready depends only on the skid register, so out_ready never reaches in_ready.
  assign bus.in_ready = !s_valid_q;
  assign accept       = bus.in_valid && !s_valid_q;

  // Next-state for M/S: flush, then skid drain, then accept into M or S, then M drain.
  always_comb begin
    m_valid_d = m_valid_q;
    m_lv_d    = m_lv_q;
    m_imm_d   = m_imm_q;
    m_tgt_d   = m_tgt_q;
    s_valid_d = s_valid_q;
    s_lv_d    = s_lv_q;
    s_imm_d   = s_imm_q;
    s_tgt_d   = s_tgt_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (s_valid_q && bus.out_ready) begin
      m_valid_d = 1'b1;
      m_lv_d    = s_lv_q;
      m_imm_d   = s_imm_q;
      m_tgt_d   = s_tgt_q;
      s_valid_d = 1'b0;
    end else if (accept && (!m_valid_q || bus.out_ready)) begin
      m_valid_d = 1'b1;
      m_lv_d    = bus.in_lane_valid;
      m_imm_d   = in_imm;
      m_tgt_d   = in_target;
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_lv_d    = bus.in_lane_valid;
      s_imm_d   = in_imm;
      s_tgt_d   = in_target;
    end else if (m_valid_q && bus.out_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // Register update; reset clears both stages and their payloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_lv_q    <= '0;
      m_imm_q   <= '0;
      m_tgt_q   <= '0;
      s_valid_q <= 1'b0;
      s_lv_q    <= '0;
      s_imm_q   <= '0;
      s_tgt_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_lv_q    <= m_lv_d;
      m_imm_q   <= m_imm_d;
      m_tgt_q   <= m_tgt_d;
      s_valid_q <= s_valid_d;
      s_lv_q    <= s_lv_d;
      s_imm_q   <= s_imm_d;
      s_tgt_q   <= s_tgt_d;
    end
  end

  assign bus.out_valid      = m_valid_q;
  assign bus.out_lane_valid = m_lv_q;
  assign bus.out_imm        = m_imm_q;
  assign bus.out_target     = m_tgt_q;

endmodule
